// File: rtl/fifo_tx_pkg.sv
// Shared types and frame constants for the FIFO-draining UART transmitter.
package fifo_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Free-running bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Wrapping on tick lets consecutive bit periods run without a clear cycle.
  always_comb begin
    if (clr || tick) cnt_d = '0;
    else             cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO read port and sends each as an 8N1 frame on tx.
module fifo_uart_tx
  import fifo_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic [15:0]       frames_sent
);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_q, bit_d;
  logic [15:0]       frames_q, frames_d;
  logic              tx_q, tx_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              tick;
  logic              timer_clr;
  logic              frame_done;

  assign timer_clr = !(state_q inside {START, DATA, STOP});

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr),
    .tick(tick)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    frame_done = 1'b0;
    frames_d   = frames_q + 16'd1;
    case (state_q)
      IDLE: if (enable && !fifo_empty) state_d = POP;
      POP:  state_d = LOAD;
      LOAD: begin
        shift_d = fifo_data;
        bit_d   = '0;
        state_d = START;
      end
      START: if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          frame_done = 1'b1;
          state_d    = (enable && !fifo_empty) ? POP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins align with state_q.
  always_comb begin
    rd_en_d = (state_d == POP);
    busy_d  = (state_d != IDLE);
    case (state_d)
      START:   tx_d = START_LEVEL;
      DATA:    tx_d = shift_d[0];
      STOP:    tx_d = STOP_LEVEL;
      default: tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= IDLE_LEVEL;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)             frames_q <= '0;
    else if (frame_done) frames_q <= frames_d;
  end

  assign fifo_rd_en  = rd_en_q;
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboarded bench: FIFO model feeds the DUT, a serial receiver decodes tx frames.
module tb_fifo_uart_tx;
  import fifo_tx_pkg::*;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        tx;
  logic        busy;
  logic [15:0] frames_sent;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  // FIFO model with registered read data
  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_cnt = 0;
  bit pop_empty_err = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (fifo_empty) pop_empty_err <= 1'b1;
      else begin
        fifo_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  // Serial receiver sampling on the falling edge
  int         rx_cnt = 0;
  bit         rx_busy = 1'b0;
  int         rx_c = 0;
  logic [9:0] rx_raw = '0;
  bit         rx_glitch = 1'b0;
  int         idle_run = 0;
  bit         busy_err = 1'b0;
  logic [7:0] rx_byte [0:31];
  bit         rx_ok   [0:31];
  int         rx_gap  [0:31];

  always @(negedge clk) begin
    if (rst) begin
      rx_busy  = 1'b0;
      idle_run = 0;
    end else begin
      if (!rx_busy && tx === 1'b0) begin
        rx_busy         = 1'b1;
        rx_c            = 0;
        rx_glitch       = 1'b0;
        rx_gap[rx_cnt]  = idle_run;
      end
      if (rx_busy) begin
        if (busy !== 1'b1) busy_err = 1'b1;
        if (rx_c % CPB == 0)                  rx_raw[rx_c / CPB] = tx;
        else if (tx !== rx_raw[rx_c / CPB])   rx_glitch = 1'b1;
        if (rx_c == FRAME_CYC - 1) begin
          rx_byte[rx_cnt] = rx_raw[8:1];
          rx_ok[rx_cnt]   = !rx_glitch && (rx_raw[0] === 1'b0) && (rx_raw[9] === 1'b1);
          rx_cnt          = rx_cnt + 1;
          rx_busy         = 1'b0;
          idle_run        = 0;
        end else begin
          rx_c = rx_c + 1;
        end
      end else begin
        idle_run = idle_run + 1;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 1;
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int k = 0;
    while (rx_cnt < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    ok = (rx_cnt >= n);
  endtask

  task automatic wait_bit(input int c_min, input int budget, output bit ok);
    int k = 0;
    ok = 1'b0;
    while (!ok && k < budget) begin
      @(posedge clk);
      #1;
      k++;
      ok = rx_busy && (rx_c >= c_min);
    end
  endtask

  task automatic test_reset();
    enable = 1'b1;
    rst    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) rst = 1'b0;
      n_total++;
      if ({tx, fifo_rd_en, busy, frames_sent} !== {1'b1, 1'b0, 1'b0, 16'h0000})
        $display("FAIL reset_idle[%0d]: tx=%b rd_en=%b busy=%b frames=%h, expected 1 0 0 0000",
                 i, tx, fifo_rd_en, busy, frames_sent);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    bit ok;
    int base = rx_cnt;
    int rd0  = rd_cnt;
    logic [7:0] e;
    push(8'hA5);
    @(posedge clk); #1;
    n_total++;
    if ({fifo_rd_en, tx, busy} !== 3'b111)
      $display("FAIL single_pop: rd_en=%b tx=%b busy=%b, expected 1 1 1", fifo_rd_en, tx, busy);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({fifo_rd_en, tx} !== 2'b01)
      $display("FAIL single_load: rd_en=%b tx=%b, expected 0 1", fifo_rd_en, tx);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (tx !== START_LEVEL) $display("FAIL single_start_latency: tx=%b, expected 0", tx);
    else n_pass++;
    wait_rx(base + 1, FRAME_CYC + 20, ok);
    n_total++;
    if (!ok) $display("FAIL single_timeout: frames seen %0d, expected %0d", rx_cnt - base, 1);
    else n_pass++;
    n_total++;
    if ({busy, tx, frames_sent} !== {1'b0, 1'b1, 16'd1})
      $display("FAIL single_end: busy=%b tx=%b frames=%0d, expected 0 1 1", busy, tx, frames_sent);
    else n_pass++;
    n_total++;
    if (rd_cnt - rd0 !== 1) $display("FAIL single_rd_pulses: got %0d, expected 1", rd_cnt - rd0);
    else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if (rx_byte[base] !== e || !rx_ok[base])
      $display("FAIL single_byte: got %h ok=%0d, expected %h ok=1", rx_byte[base], rx_ok[base], e);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base, rd0;
    logic [7:0] e;
    do_reset();
    base = rx_cnt;
    rd0  = rd_cnt;
    push(8'h00);
    push(8'hFF);
    wait_rx(base + 2, 2 * FRAME_CYC + 30, ok);
    n_total++;
    if (!ok) $display("FAIL b2b_timeout: frames seen %0d, expected 2", rx_cnt - base);
    else n_pass++;
    n_total++;
    if (rx_gap[base + 1] !== 2) $display("FAIL b2b_gap: got %0d high cycles, expected 2", rx_gap[base + 1]);
    else n_pass++;
    n_total++;
    if (rd_cnt - rd0 !== 2) $display("FAIL b2b_rd_pulses: got %0d, expected 2", rd_cnt - rd0);
    else n_pass++;
    n_total++;
    if ({busy, frames_sent} !== {1'b0, 16'd2})
      $display("FAIL b2b_end: busy=%b frames=%0d, expected 0 2", busy, frames_sent);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      n_total++;
      if (rx_byte[base + k] !== e || !rx_ok[base + k])
        $display("FAIL b2b_byte[%0d]: got %h ok=%0d, expected %h ok=1",
                 k, rx_byte[base + k], rx_ok[base + k], e);
      else n_pass++;
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int base, rd0;
    logic [7:0] e;
    do_reset();
    base = rx_cnt;
    rd0  = rd_cnt;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    wait_bit(2 * CPB + 2, 40, ok);
    enable = 1'b0;
    n_total++;
    if (!ok) $display("FAIL endrop_reach_data: receiver not in data bits, expected data phase");
    else n_pass++;
    wait_rx(base + 1, FRAME_CYC + 20, ok);
    repeat (2 * FRAME_CYC) @(posedge clk);
    #1;
    n_total++;
    if (!ok || rx_cnt - base !== 1)
      $display("FAIL endrop_frames: got %0d frames, expected 1", rx_cnt - base);
    else n_pass++;
    n_total++;
    if (rd_cnt - rd0 !== 1) $display("FAIL endrop_rd_pulses: got %0d, expected 1", rd_cnt - rd0);
    else n_pass++;
    n_total++;
    if ({busy, tx, frames_sent} !== {1'b0, 1'b1, 16'd1})
      $display("FAIL endrop_idle: busy=%b tx=%b frames=%0d, expected 0 1 1", busy, tx, frames_sent);
    else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if (rx_byte[base] !== e || !rx_ok[base])
      $display("FAIL endrop_byte: got %h ok=%0d, expected %h ok=1", rx_byte[base], rx_ok[base], e);
    else n_pass++;
    enable = 1'b1;
    wait_rx(base + 3, 2 * FRAME_CYC + 30, ok);
    @(posedge clk); #1;
    n_total++;
    if (!ok || frames_sent !== 16'd3)
      $display("FAIL endrop_resume: frames=%0d, expected 3", frames_sent);
    else n_pass++;
    for (int k = 1; k < 3; k++) begin
      e = exp_q.pop_front();
      n_total++;
      if (rx_byte[base + k] !== e || !rx_ok[base + k])
        $display("FAIL endrop_byte[%0d]: got %h ok=%0d, expected %h ok=1",
                 k, rx_byte[base + k], rx_ok[base + k], e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base, rd0;
    logic [7:0] e;
    base = rx_cnt;
    push(8'h5A);
    wait_bit(4 * CPB + 1, 40, ok);
    rst = 1'b1;
    n_total++;
    if (!ok) $display("FAIL rstmid_reach_bit3: receiver not at data bit 3, expected bit 3");
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({tx, busy, fifo_rd_en, frames_sent} !== {1'b1, 1'b0, 1'b0, 16'd0})
      $display("FAIL rstmid_abort: tx=%b busy=%b rd_en=%b frames=%0d, expected 1 0 0 0",
               tx, busy, fifo_rd_en, frames_sent);
    else n_pass++;
    rst = 1'b0;
    void'(exp_q.pop_front());
    rd0 = rd_cnt;
    repeat (FRAME_CYC) @(posedge clk);
    #1;
    n_total++;
    if (rx_cnt !== base || busy !== 1'b0)
      $display("FAIL rstmid_no_partial: frames=%0d busy=%b, expected %0d 0", rx_cnt, busy, base);
    else n_pass++;
    push(8'hC3);
    wait_rx(base + 1, FRAME_CYC + 20, ok);
    n_total++;
    if (!ok || frames_sent !== 16'd1 || rd_cnt - rd0 !== 1)
      $display("FAIL rstmid_restart: frames=%0d rd=%0d, expected 1 1", frames_sent, rd_cnt - rd0);
    else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if (rx_byte[base] !== e || !rx_ok[base])
      $display("FAIL rstmid_byte: got %h ok=%0d, expected %h ok=1", rx_byte[base], rx_ok[base], e);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok;
    int base;
    logic [7:0] e;
    do_reset();
    base = rx_cnt;
    force dut.frames_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frames_q;
    @(posedge clk); #1;
    n_total++;
    if (frames_sent !== 16'hFFFF) $display("FAIL wrap_preload: got %h, expected ffff", frames_sent);
    else n_pass++;
    push(8'h3C);
    wait_rx(base + 1, FRAME_CYC + 20, ok);
    n_total++;
    if (!ok || frames_sent !== 16'h0000) $display("FAIL wrap_count: got %h, expected 0000", frames_sent);
    else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if (rx_byte[base] !== e || !rx_ok[base])
      $display("FAIL wrap_byte: got %h ok=%0d, expected %h ok=1", rx_byte[base], rx_ok[base], e);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    test_wrap();
    n_total++;
    if (busy_err !== 1'b0) $display("FAIL busy_in_frame: busy dropped during a frame, expected high");
    else n_pass++;
    n_total++;
    if (pop_empty_err !== 1'b0) $display("FAIL pop_when_empty: rd_en seen with FIFO empty, expected none");
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Consumer-side block for the team's 8-bit FIFO: pops bytes through the FIFO read port (read_en / empty / data_out) and transmits each as an asynchronous serial frame (1 start bit, 8 data bits LSB-first, 1 stop bit). It sits between the FIFO and the board-level serial output pin and drains the buffer autonomously while enabled.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535
DATA_W, 8, data width; fixed to match FIFO width, not to be overridden

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
enable  input  1  permits starting a new frame; sampled only in IDLE and at end of STOP
fifo_empty  input  1  FIFO empty flag
fifo_data  input  8  FIFO registered read data, valid the cycle after fifo_rd_en
fifo_rd_en  output  1  one-cycle pop request to FIFO
tx  output  1  serial line, idle high
busy  output  1  high in any state other than IDLE
frames_sent  output  16  count of completed frames, wraps 0xFFFF->0x0000

Behaviour:
- Single clock; reset synchronous, active-high. Reset values: tx=1, fifo_rd_en=0, busy=0, frames_sent=0, state=IDLE, shift register=0, bit and tick counters=0.
- Reset mid-frame aborts: tx=1 on the next edge, no partial frame completion, no pop.
- States: IDLE, POP, LOAD, START, DATA, STOP. All outputs are registered / Moore.
- IDLE: tx=1. If enable=1 and fifo_empty=0 -> POP; else stay.
- POP (1 cycle): fifo_rd_en=1, tx=1 -> LOAD.
- LOAD (1 cycle): fifo_rd_en=0; capture fifo_data into 8-bit shift register; tick counter cleared -> START.
- START: tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: tx=shift[0]; after CLKS_PER_BIT cycles, shift right by 1 and increment bit counter 0..7; leave after bit 7 completes -> STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle, frames_sent increments. Then if enable=1 and fifo_empty=0 -> POP (back-to-back frame); else -> IDLE.
- Frame timing: 10*CLKS_PER_BIT cycles of tx activity. Gap between back-to-back frames is exactly 2 cycles of tx=1 (POP + LOAD). Latency from IDLE seeing the condition to the falling start edge: 3 cycles.
- fifo_rd_en asserts exactly once per frame and never while fifo_empty=1 is sampled at the decision point. No pop in any other state.
- enable deasserted mid-frame: the current frame completes normally. The block then returns to IDLE without popping.
- fifo_empty changing during POP/LOAD is ignored; the byte captured in LOAD is transmitted.
- Tick counter width: $clog2(CLKS_PER_BIT); terminal count is CLKS_PER_BIT-1. Bit counter: 3 bits.

Decomposition:
- Shared package fifo_tx_pkg holds:
  - state enum (IDLE, POP, LOAD, START, DATA, STOP)
  - FRAME_BITS=10, DATA_BITS=8
  - START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1
- One natural sub-module: bit_timer. It is a CLKS_PER_BIT tick counter with synchronous clear and a one-cycle terminal-count pulse, instantiated once. The FSM, shift register and frame counter stay in fifo_uart_tx.

Test Plan:
- Reset then idle: rst high for 3 cycles, fifo_empty=1, enable=1 -> tx=1, fifo_rd_en=0, busy=0, frames_sent=0 throughout.
- Single byte, CLKS_PER_BIT=4: FIFO holds 0xA5, enable=1 -> one fifo_rd_en pulse. tx sequence, each bit 4 cycles: 0,1,0,1,0,0,1,0,1,1. frames_sent=1; busy falls after 40 tx cycles.
- Back-to-back: FIFO holds 0x00, 0xFF -> two frames separated by exactly 2 high cycles. Exactly 2 rd_en pulses; frames_sent=2.
- enable drop mid-frame: deassert during DATA of the first of 3 queued bytes -> that frame completes, no further pop, state IDLE, frames_sent=1.
- Reset mid-frame: assert rst during DATA bit 3 -> next edge tx=1, busy=0; frames_sent=0; after release with data queued, a clean new frame starts.
- Counter wrap: preload frames_sent to 0xFFFF via force, send one byte -> frames_sent=0x0000.
